// File: rtl/mem_access_controller.sv
// Memory-stage sequencer: legality check, data-memory strobes and MEM/WB capture.
// Each legal load/store occupies the data memory for MEM_LATENCY cycles while
// upstream stages are stalled; illegal accesses raise a one-cycle exception
// and retire as a bubble.
module mem_access_controller #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_load_mode,
  input  logic [31:0] ex_address,
  input  logic [31:0] ex_write_data,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_rd,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [1:0]  dm_load_mode,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_read_data,
  output logic        stall,
  output logic        misalign_exc,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CW = $clog2(MEM_LATENCY) + 1;
  localparam int START = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
  localparam logic [CW-1:0] CNT_START = CW'(START);
  localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic mem_op;
  logic word_acc;
  logic half_acc;
  logic illegal_op;
  logic legal_op;
  logic in_idle;
  logic in_access;
  logic active;
  logic final_cycle;

  // Decode the presented access, decide legality and derive the stall/strobe windows.
  // Everything combinational is forced low while reset is held so the memory sees
  // no strobe the instant reset rises.
  always_comb begin
    mem_op      = ex_valid & (ex_mem_read | ex_mem_write);
    word_acc    = ex_mem_write | (ex_mem_read & (ex_load_mode == 2'b00));
    half_acc    = ex_mem_read & ((ex_load_mode == 2'b01) | (ex_load_mode == 2'b10));
    illegal_op  = mem_op & ((ex_mem_read & ex_mem_write) |
                            (ex_mem_read & (ex_load_mode == 2'b11)) |
                            (word_acc & (ex_address[1:0] != 2'b00)) |
                            (half_acc & ex_address[0]));
    legal_op    = mem_op & ~illegal_op;
    in_idle     = (state == IDLE);
    in_access   = (state == ACCESS);
    active      = ~reset & ((in_idle & legal_op) | in_access);
    final_cycle = (in_access & (cnt == '0)) | (in_idle & SINGLE_CYCLE);
    stall        = active & ~final_cycle;
    misalign_exc = ~reset & in_idle & illegal_op;
    dm_mem_read   = active ? ex_mem_read   : 1'b0;
    dm_mem_write  = active ? ex_mem_write  : 1'b0;
    dm_load_mode  = active ? ex_load_mode  : 2'b00;
    dm_address    = active ? ex_address    : 32'h0;
    dm_write_data = active ? ex_write_data : 32'h0;
  end

  // Access sequencing FSM plus the MEM/WB pipeline register; a reset mid-access
  // simply abandons it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (legal_op && !SINGLE_CYCLE) begin
            state <= ACCESS;
            cnt   <= CNT_START;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (stall || !ex_valid || illegal_op) begin
        wb_valid     <= 1'b0;
        wb_reg_write <= 1'b0;
        wb_rd        <= 5'd0;
        wb_data      <= 32'h0;
      end else begin
        wb_valid     <= 1'b1;
        wb_reg_write <= ex_reg_write;
        wb_rd        <= ex_rd;
        wb_data      <= ex_mem_to_reg ? dm_read_data : ex_address;
      end
    end
  end

endmodule
